// File: rtl/dmem_responder.sv
// M-stage data-memory responder: one load or store per instruction,
// served after LATENCY wait cycles with byte/half/word sizing.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic        unsignedM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        resp_validM,
    output logic        stallM,
    output logic        errM
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t stateNext;

    logic [3:0]  count;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [31:0] reqData;

    logic [31:0] mem [DEPTH];

    logic        selWrite;
    logic [1:0]  selSize;
    logic        selUnsigned;
    logic [31:0] selAddr;
    logic [31:0] selData;

    logic [31:0] off;
    logic [IW-1:0] idx;
    logic        inRange;
    logic        misaligned;
    logic        accErr;
    logic [31:0] memWord;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;
    logic [31:0] respData;
    logic [31:0] storeWord;
    logic        memWe;

    // In IDLE the live request is decoded so LATENCY=0 can respond directly
    assign selWrite    = (state == IDLE) ? memwriteM  : reqWrite;
    assign selSize     = (state == IDLE) ? sizeM      : reqSize;
    assign selUnsigned = (state == IDLE) ? unsignedM  : reqUnsigned;
    assign selAddr     = (state == IDLE) ? addrM      : reqAddr;
    assign selData     = (state == IDLE) ? writedataM : reqData;

    assign off     = selAddr - ADDR_BASE;
    assign idx     = off[IW+1:2];
    assign inRange = (selAddr >= ADDR_BASE) && (off[31:2] < 30'(DEPTH));

    always_comb begin
        misaligned = 1'b0;
        case (selSize)
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign accErr  = !inRange || misaligned || (selSize == 2'b11);
    assign memWord = mem[idx];
    assign byteSel = memWord[{off[1:0], 3'b000} +: 8];
    assign halfSel = off[1] ? memWord[31:16] : memWord[15:0];

    always_comb begin
        loadData = '0;
        case (selSize)
            2'b00: loadData = {{24{!selUnsigned && byteSel[7]}}, byteSel};
            2'b01: loadData = {{16{!selUnsigned && halfSel[15]}}, halfSel};
            2'b10: loadData = memWord;
            default: loadData = '0;
        endcase
    end

    assign respData = (accErr || selWrite) ? 32'h0 : loadData;

    // Read-modify-write keeps the untouched lanes of the word
    always_comb begin
        storeWord = memWord;
        case (selSize)
            2'b00: storeWord[{off[1:0], 3'b000} +: 8] = selData[7:0];
            2'b01: begin
                if (off[1])
                    storeWord[31:16] = selData[15:0];
                else
                    storeWord[15:0] = selData[15:0];
            end
            2'b10: storeWord = selData;
            default: storeWord = memWord;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (memreqM)
                    stateNext = (LATENCY > 0) ? WAIT : RESP;
            end
            WAIT: begin
                if (!memreqM)
                    stateNext = IDLE;
                else if (count == 4'd1)
                    stateNext = RESP;
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        resp_validM = (state == RESP);
        stallM      = memreqM && (state != RESP) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 4'd0;
            reqWrite    <= 1'b0;
            reqSize     <= 2'b00;
            reqUnsigned <= 1'b0;
            reqAddr     <= 32'h0;
            reqData     <= 32'h0;
        end else if (state == IDLE && memreqM) begin
            count       <= 4'(LATENCY);
            reqWrite    <= memwriteM;
            reqSize     <= sizeM;
            reqUnsigned <= unsignedM;
            reqAddr     <= addrM;
            reqData     <= writedataM;
        end else if (state == WAIT) begin
            count <= count - 4'd1;
        end
    end

    // Response data is registered on the edge entering RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            readdataM <= 32'h0;
            errM      <= 1'b0;
        end else if (stateNext == RESP) begin
            readdataM <= respData;
            errM      <= accErr;
        end else begin
            readdataM <= 32'h0;
            errM      <= 1'b0;
        end
    end

    assign memWe = (state == RESP) && selWrite && !errM && !rst;

    always_ff @(posedge clk) begin
        if (memWe)
            mem[idx] <= storeWord;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 and LATENCY=0 instances
// driven through one access task, responses popped at the falling edge.
module tb_dmem_responder;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreq [2];
    logic        memwrite [2];
    logic [1:0]  size [2];
    logic        uns [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        respValid [2];
    logic        stall [2];
    logic        err [2];

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t e0;
    exp_t e1;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_BASE(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .memreqM(memreq[0]), .memwriteM(memwrite[0]), .sizeM(size[0]),
        .unsignedM(uns[0]), .addrM(addr[0]), .writedataM(wdata[0]),
        .readdataM(rdata[0]), .resp_validM(respValid[0]),
        .stallM(stall[0]), .errM(err[0])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(0), .ADDR_BASE(32'h0)) u_dut0 (
        .clk(clk), .rst(rst),
        .memreqM(memreq[1]), .memwriteM(memwrite[1]), .sizeM(size[1]),
        .unsignedM(uns[1]), .addrM(addr[1]), .writedataM(wdata[1]),
        .readdataM(rdata[1]), .resp_validM(respValid[1]),
        .stallM(stall[1]), .errM(err[1])
    );

    task automatic checkVal(string tag, logic [31:0] got, logic [31:0] want);
        nChecks++;
        if (got === want)
            nPass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    always @(negedge clk) begin
        if (respValid[0] === 1'b1) begin
            if (q0.size() == 0) begin
                checkVal("unexpectedResp0", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                checkVal({e0.tag, ".data"}, rdata[0], e0.data);
                checkVal({e0.tag, ".err"}, {31'b0, err[0]}, {31'b0, e0.err});
            end
        end
    end

    always @(negedge clk) begin
        if (respValid[1] === 1'b1) begin
            if (q1.size() == 0) begin
                checkVal("unexpectedResp1", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                checkVal({e1.tag, ".data"}, rdata[1], e1.data);
                checkVal({e1.tag, ".err"}, {31'b0, err[1]}, {31'b0, e1.err});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the RESP cycle
    task automatic access(input int u, input string tag, input logic wr,
                          input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] expData, input logic expErr,
                          input bit b2b);
        exp_t e;
        int   lat;
        int   cycles;
        int   stalls;
        bit   done;
        lat    = (u == 0) ? 2 : 0;
        e.tag  = tag;
        e.data = expData;
        e.err  = expErr;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
        memreq[u]   = 1'b1;
        memwrite[u] = wr;
        size[u]     = sz;
        uns[u]      = un;
        addr[u]     = a;
        wdata[u]    = wd;
        cycles = 0;
        stalls = 0;
        done   = 1'b0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (stall[u] === 1'b1) stalls++;
            if (respValid[u] === 1'b1) done = 1'b1;
        end
        if (!done) begin
            checkVal({tag, ".timeout"}, 32'd0, 32'd1);
            memreq[u] = 1'b0;
            return;
        end
        checkVal({tag, ".cycles"}, cycles, lat + 2);
        checkVal({tag, ".stalls"}, stalls, lat + 1);
        @(posedge clk);
        #1;
        if (!b2b) begin
            memreq[u] = 1'b0;
            @(negedge clk);
            checkVal({tag, ".respOnce"}, {31'b0, respValid[u]}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            memreq[i]   = 1'b0;
            memwrite[i] = 1'b0;
            size[i]     = 2'b10;
            uns[i]      = 1'b0;
            addr[i]     = 32'h0;
            wdata[i]    = 32'h0;
        end
        memreq[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst.rdata", rdata[0], 32'h0);
        checkVal("rst.valid", {31'b0, respValid[0]}, 32'd0);
        checkVal("rst.err", {31'b0, err[0]}, 32'd0);
        checkVal("rst.stall", {31'b0, stall[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        memreq[0] = 1'b0;
        @(posedge clk);
        #1;

        access(0, "sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        access(0, "lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

        access(0, "sw20", 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 32'h0, 0, 0);
        access(0, "lb22", 0, 2'b00, 0, 32'h22, 32'h0, 32'hFFFFFFFF, 0, 0);
        access(0, "lbu23", 0, 2'b00, 1, 32'h23, 32'h0, 32'h00000080, 0, 0);
        access(0, "lh22", 0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFF80FF, 0, 0);
        access(0, "lhu20", 0, 2'b01, 1, 32'h20, 32'h0, 32'h00007F01, 0, 0);

        access(0, "sw30", 1, 2'b10, 0, 32'h30, 32'h11223344, 32'h0, 0, 0);
        access(0, "sb31", 1, 2'b00, 0, 32'h31, 32'h000000AA, 32'h0, 0, 0);
        access(0, "sh32", 1, 2'b01, 0, 32'h32, 32'h0000BEEF, 32'h0, 0, 0);
        access(0, "lw30", 0, 2'b10, 0, 32'h30, 32'h0, 32'hBEEFAA44, 0, 0);

        access(0, "sw40", 1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 0, 0);
        access(0, "lw41", 0, 2'b10, 0, 32'h41, 32'h0, 32'h0, 1, 0);
        access(0, "sh43", 1, 2'b01, 0, 32'h43, 32'h0000FFFF, 32'h0, 1, 0);
        access(0, "lw40", 0, 2'b10, 0, 32'h40, 32'h0, 32'h12345678, 0, 0);
        access(0, "lwOor", 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, 0);
        access(0, "sz11", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 0);

        // Flush in the first WAIT cycle: no write, no response
        access(0, "sw50", 1, 2'b10, 0, 32'h50, 32'h55555555, 32'h0, 0, 0);
        memreq[0]   = 1'b1;
        memwrite[0] = 1'b1;
        size[0]     = 2'b10;
        addr[0]     = 32'h50;
        wdata[0]    = 32'hAAAAAAAA;
        @(posedge clk);
        #1;
        memreq[0] = 1'b0;
        @(negedge clk);
        checkVal("abort.stall", {31'b0, stall[0]}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        access(0, "lw50", 0, 2'b10, 0, 32'h50, 32'h0, 32'h55555555, 0, 0);

        // Reset during WAIT of a store
        access(0, "sw60", 1, 2'b10, 0, 32'h60, 32'h66666666, 32'h0, 0, 0);
        memreq[0]   = 1'b1;
        memwrite[0] = 1'b1;
        size[0]     = 2'b10;
        addr[0]     = 32'h60;
        wdata[0]    = 32'h77777777;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkVal("rstMid.stall", {31'b0, stall[0]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        memreq[0] = 1'b0;
        @(negedge clk);
        checkVal("rstMid.rdata", rdata[0], 32'h0);
        checkVal("rstMid.valid", {31'b0, respValid[0]}, 32'd0);
        checkVal("rstMid.err", {31'b0, err[0]}, 32'd0);
        checkVal("rstMid.stall", {31'b0, stall[0]}, 32'd0);
        @(posedge clk);
        #1;
        access(0, "lw60", 0, 2'b10, 0, 32'h60, 32'h0, 32'h66666666, 0, 0);

        // LATENCY=0 instance: setup stores, then four back-to-back loads
        for (int i = 0; i < 4; i++)
            access(1, $sformatf("l0sw%0d", i), 1, 2'b10, 0, 32'(i * 4),
                   32'hC0DE0000 + 32'(i), 32'h0, 0, 0);
        for (int i = 0; i < 4; i++)
            access(1, $sformatf("l0lw%0d", i), 0, 2'b10, 0, 32'(i * 4),
                   32'h0, 32'hC0DE0000 + 32'(i), 0, 1);
        memreq[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        checkVal("q0Empty", q0.size(), 32'd0);
        checkVal("q1Empty", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
